// File: rtl/uart_mmio_pkg.sv
// Shared register offsets, status bit positions and the status word layout
// for the memory-mapped UART bridge.
package uart_mmio_pkg;

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_RX     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;

    // Field order matches the STATUS bit indices above (msb first).
    typedef struct packed {
        logic tx_overflow;
        logic rx_overrun;
        logic rx_full;
        logic rx_nonempty;
        logic tx_empty;
        logic tx_full;
    } status_t;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Single-clock FIFO with registered pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    // Empty reads as zero so stale entries never leak onto outputs.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_mmio.sv
// Load/store window exposing a TX FIFO, an RX FIFO and a status register,
// bridged to the UART AXI-stream byte interfaces.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        i_read_req,
    input  logic [31:0] i_read_addr,
    output logic [31:0] o_read_data,
    output logic        o_read_hit,
    input  logic        i_write_enable,
    input  logic [3:0]  i_byte_enable,
    input  logic [31:0] i_write_addr,
    input  logic [31:0] i_write_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready
);

    logic                        w_rd_hit, w_wr_hit;
    logic [1:0]                  w_rd_off, w_wr_off;
    logic                        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic                        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [7:0]                  w_tx_head, w_rx_head;
    logic [$clog2(TX_DEPTH):0]   w_tx_count;
    logic [$clog2(RX_DEPTH):0]   w_rx_count;
    logic                        w_st_wr, w_tx_ovf_set, w_rx_ovr_set;
    logic                        r_tx_overflow, r_rx_overrun;
    logic                        r_read_hit;
    logic [31:0]                 r_read_data;
    logic [31:0]                 w_rd_mux;
    status_t                     w_status;
    logic                        w_unused;

    assign w_rd_hit = i_read_req & (i_read_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_hit = i_write_enable & (i_write_addr[31:4] == BASE_ADDR[31:4]);
    assign w_rd_off = i_read_addr[3:2];
    assign w_wr_off = i_write_addr[3:2];

    assign w_tx_push = clk_en & w_wr_hit & (w_wr_off == OFF_TX) & i_byte_enable[0];
    assign w_tx_pop  = o_tx_valid & i_tx_ready;
    assign w_rx_push = clk_en & i_rx_valid;
    assign w_rx_pop  = clk_en & w_rd_hit & (w_rd_off == OFF_RX) & ~w_rx_empty;
    assign w_st_wr   = clk_en & w_wr_hit & (w_wr_off == OFF_STATUS) & i_byte_enable[0];

    // A push into a full FIFO only loses data when no pop frees a slot.
    assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;
    assign w_rx_ovr_set = w_rx_push & w_rx_full & ~w_rx_pop;

    assign o_tx_valid = ~w_tx_empty & clk_en;
    assign o_tx_data  = w_tx_head;
    assign o_rx_ready = clk_en;
    assign o_read_data = r_read_data;
    assign o_read_hit  = r_read_hit;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  (i_write_data[7:0]),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (i_rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    always_comb begin
        w_status             = '0;
        w_status.tx_full     = w_tx_full;
        w_status.tx_empty    = w_tx_empty;
        w_status.rx_nonempty = ~w_rx_empty;
        w_status.rx_full     = w_rx_full;
        w_status.rx_overrun  = r_rx_overrun;
        w_status.tx_overflow = r_tx_overflow;
    end

    // Reads sample pre-cycle state; same-cycle pops land after the sample.
    always_comb begin
        w_rd_mux = '0;
        case (w_rd_off)
            OFF_RX:     w_rd_mux = {23'b0, ~w_rx_empty, w_rx_head};
            OFF_STATUS: w_rd_mux = {26'b0, w_status};
            default:    w_rd_mux = '0;
        endcase
    end

    // Sticky flags: a set event in the same cycle beats a write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_overflow <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else if (clk_en) begin
            if (w_tx_ovf_set)
                r_tx_overflow <= 1'b1;
            else if (w_st_wr & i_write_data[ST_TX_OVERFLOW])
                r_tx_overflow <= 1'b0;
            if (w_rx_ovr_set)
                r_rx_overrun <= 1'b1;
            else if (w_st_wr & i_write_data[ST_RX_OVERRUN])
                r_rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_hit  <= 1'b0;
            r_read_data <= '0;
        end else if (clk_en) begin
            r_read_hit  <= w_rd_hit;
            r_read_data <= w_rd_hit ? w_rd_mux : '0;
        end
    end

    assign w_unused = ^{i_read_addr[1:0], i_write_addr[1:0], i_byte_enable[3:1],
                        i_write_data[31:8], w_tx_count, w_rx_count};

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: window decode, TX/RX FIFOs, sticky flags,
// clock enable and asynchronous reset.
module tb_uart_mmio;

    localparam logic [31:0] TXA = 32'h1000_0000;
    localparam logic [31:0] RXA = 32'h1000_0004;
    localparam logic [31:0] STA = 32'h1000_0008;
    localparam logic [31:0] RSV = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic        i_read_req;
    logic [31:0] i_read_addr;
    logic [31:0] o_read_data;
    logic        o_read_hit;
    logic        i_write_enable;
    logic [3:0]  i_byte_enable;
    logic [31:0] i_write_addr, i_write_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, i_tx_ready;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid, o_rx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_mmio dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .i_read_req     (i_read_req),
        .i_read_addr    (i_read_addr),
        .o_read_data    (o_read_data),
        .o_read_hit     (o_read_hit),
        .i_write_enable (i_write_enable),
        .i_byte_enable  (i_byte_enable),
        .i_write_addr   (i_write_addr),
        .i_write_data   (i_write_data),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rx_ready     (o_rx_ready)
    );

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        i_write_enable = 1'b1; i_write_addr = a; i_write_data = d; i_byte_enable = be;
        @(negedge clk);
        i_write_enable = 1'b0; i_byte_enable = 4'h0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        i_read_req = 1'b1; i_read_addr = a;
        @(posedge clk);
        #1;
        d = o_read_data; h = o_read_hit;
        i_read_req = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        i_rx_valid = 1'b1; i_rx_data = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h;
        rst = 1'b1; clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", o_tx_valid); end
        n_tests++; if (o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", o_tx_data); end
        n_tests++; if (o_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", o_rx_ready); end
        n_tests++; if (o_read_hit !== 1'b0) begin n_fail++; $display("FAIL reset_read_hit: got %b want 0", o_read_hit); end
        n_tests++; if (o_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h want 0", o_read_data); end
        @(negedge clk); rst = 1'b0;
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", d); end
        n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL reset_status_hit: got %b want 1", h); end
        @(posedge clk); #1;
        n_tests++; if (o_read_hit !== 1'b0) begin n_fail++; $display("FAIL idle_read_hit: got %b want 0", o_read_hit); end
        cpu_read(32'h2000_0008, d, h);
        n_tests++; if (h !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL miss_read: got hit=%b data=%h want hit=0 data=0", h, d); end
        cpu_read(RSV, d, h);
        n_tests++; if (h !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got hit=%b data=%h want hit=1 data=0", h, d); end
        cpu_write(32'h1000_0010, 32'h5A, 4'h1);
        cpu_write(RSV, 32'h5A, 4'hF);
        #1;
        n_tests++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL miss_write_push: got valid=%b want 0", o_tx_valid); end
    endtask

    task automatic test_tx_stream();
        i_tx_ready = 1'b0;
        cpu_write(TXA, 32'h41, 4'h1);
        cpu_write(TXA, 32'h42, 4'h1);
        cpu_write(TXA, 32'h43, 4'h1);
        #1;
        n_tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_hold: got valid=%b data=%h want 1/41", o_tx_valid, o_tx_data); end
        @(negedge clk); i_tx_ready = 1'b1;
        #1;
        n_tests++; if (o_tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_byte0: got %h want 41", o_tx_data); end
        @(posedge clk); #1;
        n_tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h42) begin n_fail++; $display("FAIL tx_byte1: got valid=%b data=%h want 1/42", o_tx_valid, o_tx_data); end
        @(posedge clk); #1;
        n_tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h43) begin n_fail++; $display("FAIL tx_byte2: got valid=%b data=%h want 1/43", o_tx_valid, o_tx_data); end
        @(posedge clk); #1;
        n_tests++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got valid=%b want 0", o_tx_valid); end
        i_tx_ready = 1'b0;
        cpu_write(TXA, 32'h77, 4'b1110);
        #1;
        n_tests++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_lane0_off: got valid=%b want 0", o_tx_valid); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d; logic h;
        logic [7:0] exp_b;
        i_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cpu_write(TXA, i, 4'h1);
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h21) begin n_fail++; $display("FAIL tx_overflow_status: got %h want 00000021", d); end
        cpu_write(STA, 32'h20, 4'h1);
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h01) begin n_fail++; $display("FAIL tx_overflow_clear: got %h want 00000001", d); end
        // push into a full FIFO while a pop happens in the same cycle
        @(negedge clk);
        i_tx_ready = 1'b1;
        i_write_enable = 1'b1; i_write_addr = TXA; i_write_data = 32'h99; i_byte_enable = 4'h1;
        @(negedge clk);
        i_tx_ready = 1'b0; i_write_enable = 1'b0; i_byte_enable = 4'h0;
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h01) begin n_fail++; $display("FAIL tx_full_push_pop: got %h want 00000001", d); end
        @(negedge clk); i_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'(i + 1) : 8'h99;
            #1;
            n_tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp_b) begin n_fail++; $display("FAIL tx_drain[%0d]: got valid=%b data=%h want 1/%h", i, o_tx_valid, o_tx_data, exp_b); end
            @(posedge clk);
        end
        #1;
        n_tests++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain_end: got valid=%b want 0", o_tx_valid); end
        i_tx_ready = 1'b0;
    endtask

    task automatic test_rx_basic();
        logic [31:0] d; logic h;
        rx_send(8'h55);
        rx_send(8'hAA);
        cpu_read(RXA, d, h);
        n_tests++; if (d !== 32'h155 || h !== 1'b1) begin n_fail++; $display("FAIL rx_read0: got %h hit=%b want 00000155 hit=1", d, h); end
        cpu_read(RXA, d, h);
        n_tests++; if (d !== 32'h1AA) begin n_fail++; $display("FAIL rx_read1: got %h want 000001aa", d); end
        cpu_read(RXA, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_read_empty: got %h want 00000000", d); end
        cpu_write(TXA, 32'h3C, 4'h1);
        cpu_read(TXA, d, h);
        n_tests++; if (d !== 32'h0 || h !== 1'b1) begin n_fail++; $display("FAIL txdata_read: got %h hit=%b want 0 hit=1", d, h); end
        @(negedge clk); i_tx_ready = 1'b1;
        @(negedge clk); i_tx_ready = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d; logic h;
        for (int i = 0; i < 9; i++) rx_send(8'(i));
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h1E) begin n_fail++; $display("FAIL rx_overrun_status: got %h want 0000001e", d); end
        // clear and a fresh overrun in the same cycle: overrun stays set
        @(negedge clk);
        i_rx_valid = 1'b1; i_rx_data = 8'hEE;
        i_write_enable = 1'b1; i_write_addr = STA; i_write_data = 32'h10; i_byte_enable = 4'h1;
        @(negedge clk);
        i_rx_valid = 1'b0; i_write_enable = 1'b0; i_byte_enable = 4'h0;
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h1E) begin n_fail++; $display("FAIL rx_set_beats_clear: got %h want 0000001e", d); end
        cpu_write(STA, 32'h10, 4'h1);
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h0E) begin n_fail++; $display("FAIL rx_overrun_clear: got %h want 0000000e", d); end
        // full FIFO, pop and push together: new byte accepted, no overrun
        @(negedge clk);
        i_rx_valid = 1'b1; i_rx_data = 8'h77; i_read_req = 1'b1; i_read_addr = RXA;
        @(posedge clk); #1;
        n_tests++; if (o_read_data !== 32'h100) begin n_fail++; $display("FAIL rx_full_pop_push: got %h want 00000100", o_read_data); end
        i_rx_valid = 1'b0; i_read_req = 1'b0;
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h0E) begin n_fail++; $display("FAIL rx_full_pop_push_status: got %h want 0000000e", d); end
        for (int i = 1; i < 8; i++) begin
            cpu_read(RXA, d, h);
            n_tests++; if (d !== (32'h100 | i)) begin n_fail++; $display("FAIL rx_drain[%0d]: got %h want %h", i, d, 32'h100 | i); end
        end
        cpu_read(RXA, d, h);
        n_tests++; if (d !== 32'h177) begin n_fail++; $display("FAIL rx_drain_last: got %h want 00000177", d); end
        cpu_read(RXA, d, h);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_drain_empty: got %h want 00000000", d); end
    endtask

    task automatic test_clk_en();
        logic [31:0] d; logic h;
        cpu_write(TXA, 32'h5A, 4'h1);
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h00 || h !== 1'b1) begin n_fail++; $display("FAIL ce_status_before: got %h hit=%b want 0 hit=1", d, h); end
        @(negedge clk);
        clk_en = 1'b0;
        i_write_enable = 1'b1; i_write_addr = TXA; i_write_data = 32'h66; i_byte_enable = 4'h1;
        i_rx_valid = 1'b1; i_rx_data = 8'h33;
        i_read_req = 1'b1; i_read_addr = 32'h2000_0000;
        i_tx_ready = 1'b1;
        #1;
        n_tests++; if (o_tx_valid !== 1'b0 || o_rx_ready !== 1'b0) begin n_fail++; $display("FAIL ce_off_outputs: got valid=%b ready=%b want 0/0", o_tx_valid, o_rx_ready); end
        @(posedge clk); #1;
        n_tests++; if (o_read_hit !== 1'b1) begin n_fail++; $display("FAIL ce_off_hold_hit: got %b want 1", o_read_hit); end
        @(negedge clk);
        i_write_enable = 1'b0; i_byte_enable = 4'h0; i_rx_valid = 1'b0; i_read_req = 1'b0;
        i_tx_ready = 1'b0; clk_en = 1'b1;
        #1;
        n_tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h5A) begin n_fail++; $display("FAIL ce_on_tx: got valid=%b data=%h want 1/5a", o_tx_valid, o_tx_data); end
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h00) begin n_fail++; $display("FAIL ce_status_after: got %h want 00000000", d); end
        @(negedge clk); i_tx_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ce_no_push: got valid=%b want 0", o_tx_valid); end
        i_tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic h;
        for (int i = 0; i < 4; i++) cpu_write(TXA, 32'h11 + i, 4'h1);
        #1;
        n_tests++; if (o_tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", o_tx_valid); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_async_reset: got valid=%b data=%h want 0/00", o_tx_valid, o_tx_data); end
        @(negedge clk); rst = 1'b0;
        cpu_read(STA, d, h);
        n_tests++; if (d !== 32'h02) begin n_fail++; $display("FAIL mid_status_after: got %h want 00000002", d); end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        i_read_req = 1'b0; i_read_addr = '0;
        i_write_enable = 1'b0; i_byte_enable = '0; i_write_addr = '0; i_write_data = '0;
        i_tx_ready = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0;
        test_reset();
        test_tx_stream();
        test_tx_overflow();
        test_rx_basic();
        test_rx_overrun();
        test_clk_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
